// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone classic-cycle constants and boot copier state encoding
package wb_pkg;
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR = 2'b00;
  localparam logic [3:0] WB_SEL_WORD = 4'b1111;
  typedef enum logic [2:0] {IDLE, RD, GAP_W, WR, GAP_R} copier_state_t;
endpackage

// File: rtl/wb_master_access.sv
// wb_master_access: single classic Wishbone access with registered bus outputs and timeout abort
module wb_master_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:2] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ok,
  output logic        o_fail,
  output logic [31:0] o_rdata,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [31:2] o_addr,
  output logic [31:0] o_wdata,
  input  logic        i_ack,
  input  logic        i_err,
  input  logic [31:0] i_rdata
);
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
  logic        r_cyc, r_stb, r_we;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic        w_timeout;
  // The count reaching TIMEOUT_CYCLES coincides with this edge, so abort now unless acked
  assign w_timeout = (r_cnt == LAST) && !i_ack;
  assign o_fail = r_stb && (i_err || w_timeout);
  assign o_ok = r_stb && i_ack && !i_err;
  assign o_rdata = i_rdata;
  assign o_cyc = r_cyc;
  assign o_stb = r_stb;
  assign o_we = r_we;
  assign o_addr = r_addr;
  assign o_wdata = r_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_cnt <= '0;
    end else if (r_stb) begin
      if (o_ok || o_fail) begin
        r_cyc <= 1'b0;
        r_stb <= 1'b0;
        r_we <= 1'b0;
      end
      if (!i_ack) r_cnt <= r_cnt + 8'd1;
    end else if (i_req) begin
      r_cyc <= 1'b1;
      r_stb <= 1'b1;
      r_we <= i_we;
      r_addr <= i_addr;
      r_wdata <= i_wdata;
      r_cnt <= '0;
    end
  end
endmodule

// File: rtl/wb_boot_copier.sv
// wb_boot_copier: Wishbone master copying a block of words (read then write per word) at boot
module wb_boot_copier
  import wb_pkg::*;
#(
  parameter int LEN_BITS = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:2]         src_addr,
  input  logic [31:2]         dst_addr,
  input  logic [LEN_BITS-1:0] word_count,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic [31:2]         wbm_addr_o,
  output logic [2:0]          wbm_cti_o,
  output logic [1:0]          wbm_bte_o,
  output logic [3:0]          wbm_sel_o,
  output logic                wbm_we_o,
  output logic [31:0]         wbm_data_o,
  input  logic [31:0]         wbm_data_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i
);
  copier_state_t       r_state, w_next;
  logic [LEN_BITS-1:0] r_idx, r_len;
  logic [31:2]         r_src, r_dst, w_addr;
  logic [31:0]         r_buf, w_rdata;
  logic                r_busy, r_done, r_error;
  logic                w_req, w_we, w_ok, w_fail, w_last;
  assign w_last = (r_idx + LEN_BITS'(1)) == r_len;
  assign busy = r_busy;
  assign done = r_done;
  assign error = r_error;
  assign wbm_cti_o = WB_CTI_CLASSIC;
  assign wbm_bte_o = WB_BTE_LINEAR;
  assign wbm_sel_o = WB_SEL_WORD;
  wb_master_access #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_access (
    .clk(clk), .rst(rst), .i_req(w_req), .i_we(w_we), .i_addr(w_addr), .i_wdata(r_buf),
    .o_ok(w_ok), .o_fail(w_fail), .o_rdata(w_rdata),
    .o_cyc(wbm_cyc_o), .o_stb(wbm_stb_o), .o_we(wbm_we_o), .o_addr(wbm_addr_o),
    .o_wdata(wbm_data_o), .i_ack(wbm_ack_i), .i_err(wbm_err_i), .i_rdata(wbm_data_i)
  );
  // Requests are raised on the edge leaving IDLE or a gap so stb rises without an extra cycle
  always_comb begin
    w_next = r_state;
    w_req = 1'b0;
    w_we = 1'b0;
    w_addr = r_src + 30'(r_idx);
    case (r_state)
      IDLE: if (start && word_count != '0) begin
        w_next = RD;
        w_req = 1'b1;
        w_addr = src_addr;
      end
      RD: w_next = w_fail ? IDLE : w_ok ? GAP_W : RD;
      GAP_W: begin
        w_next = WR;
        w_req = 1'b1;
        w_we = 1'b1;
        w_addr = r_dst + 30'(r_idx);
      end
      WR: w_next = w_fail ? IDLE : !w_ok ? WR : w_last ? IDLE : GAP_R;
      GAP_R: begin
        w_next = RD;
        w_req = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_len <= '0;
      r_src <= '0;
      r_dst <= '0;
      r_buf <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= 1'b0;
      if (r_state == IDLE && start) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_len <= word_count;
        r_idx <= '0;
        r_error <= 1'b0;
        r_busy <= word_count != '0;
        r_done <= word_count == '0;
      end
      if (r_state == RD && w_ok) r_buf <= w_rdata;
      if (r_state == WR && w_ok) r_idx <= r_idx + LEN_BITS'(1);
      if ((r_state == RD || r_state == WR) && (w_fail || (r_state == WR && w_ok && w_last))) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_error <= w_fail;
      end
    end
  end
endmodule

// File: tb/tb_wb_boot_copier.sv
// tb_wb_boot_copier: table-driven copies against a Wishbone slave model with a read/write scoreboard
module tb_wb_boot_copier;
  localparam int LB = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:2] src_addr = '0, dst_addr = '0;
  logic [LB-1:0] word_count = '0;
  logic busy, done, error, cyc, stb, we;
  logic [31:2] addr;
  logic [2:0] cti;
  logic [1:0] bte;
  logic [3:0] sel;
  logic [31:0] wdata, rdata = '0;
  logic ack = 1'b0, err = 1'b0;

  always #5 clk = ~clk;

  wb_boot_copier #(.LEN_BITS(LB), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_addr_o(addr), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_sel_o(sel), .wbm_we_o(we), .wbm_data_o(wdata), .wbm_data_i(rdata),
    .wbm_ack_i(ack), .wbm_err_i(err)
  );

  function automatic logic [31:0] data_of(input logic [31:2] a);
    return 32'hA0 + {2'b00, a} - 32'h100;
  endfunction

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slave model: registered ack after wait_n extra cycles; optional hang address and erroring write
  int wait_n = 0, err_at = -1, wr_n = 0, scnt = 0;
  logic hang_en = 1'b0;
  logic [31:2] hang_addr = '0;
  always @(posedge clk) begin
    ack <= 1'b0;
    err <= 1'b0;
    if (rst) scnt <= 0;
    else if (cyc && stb && !ack && !err && !(hang_en && addr == hang_addr)) begin
      if (scnt < wait_n) scnt <= scnt + 1;
      else begin
        scnt <= 0;
        rdata <= we ? 32'hDEADBEEF : data_of(addr);
        if (we && wr_n == err_at) begin
          err <= 1'b1;
          ack <= 1'b1;
        end else begin
          ack <= 1'b1;
          if (we) wr_n <= wr_n + 1;
        end
      end
    end
  end

  typedef struct packed {logic [31:2] a; logic [31:0] d;} wr_t;
  logic [31:2] rq[$];
  wr_t wq[$];
  wr_t ew;
  logic [31:2] ea;
  int stb_n = 0, cyc_n = 0, busy_n = 0, done_n = 0;
  logic p_stb = 1'b0, p_ack = 1'b0, p_err = 1'b0, hold_en = 1'b1;
  logic [31:2] p_addr = '0;
  always @(negedge clk) begin
    if (stb) stb_n++;
    if (cyc) cyc_n++;
    if (busy) busy_n++;
    if (done) done_n++;
    if (cyc && stb && ack && !err) begin
      if (we) begin
        check("wr_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          ew = wq.pop_front();
          check("wr_addr", addr, ew.a);
          check("wr_data", wdata, ew.d);
        end
      end else begin
        check("rd_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          ea = rq.pop_front();
          check("rd_addr", addr, ea);
        end
      end
    end
    if (hold_en && p_stb && !p_ack && !p_err) begin
      check("stb_hold", stb, 1);
      check("addr_hold", addr, p_addr);
    end
    p_stb = stb;
    p_ack = ack;
    p_err = err;
    p_addr = addr;
  end

  task automatic push_exp(input logic [31:2] s, input logic [31:2] d, input int nr, input int nw);
    for (int i = 0; i < nr; i++) rq.push_back(s + 30'(i));
    for (int i = 0; i < nw; i++) wq.push_back('{a: d + 30'(i), d: data_of(s + 30'(i))});
  endtask

  // Pulses start and returns cycles until done (1 = cycle after the start edge) and error at cycle 1
  task automatic go(input logic [31:2] s, input logic [31:2] d, input int n, input bit rs,
                    output int c, output logic e1);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    word_count = LB'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    e1 = error;
    while (!done && c < 400) begin
      @(negedge clk);
      c++;
      if (rs && c == 10) begin
        check("busy_mid", busy, 1);
        start = 1'b1;
        src_addr = 30'h777;
        dst_addr = 30'h777;
        word_count = LB'(9);
      end
      if (rs && c == 11) start = 1'b0;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  typedef struct {logic [31:2] src; logic [31:2] dst; int cnt; int wt; int lat; bit rs;} vec_t;
  vec_t v[5];
  int c, s0, b0, d0, k;
  logic e1;

  initial begin
    v[0] = '{30'h100, 30'h800, 4, 0, 24, 1'b0};
    v[1] = '{30'h0, 30'h10, 0, 0, 1, 1'b0};
    v[2] = '{30'h40, 30'h900, 3, 3, 36, 1'b1};
    v[3] = '{30'h3FFFFFFF, 30'h10, 2, 0, 12, 1'b0};
    v[4] = '{30'h123, 30'h456, 1, 1, 8, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("const_cti", cti, 3'b000);
    check("const_bte", bte, 2'b00);
    check("const_sel", sel, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      wait_n = v[i].wt;
      s0 = cyc_n;
      b0 = busy_n;
      push_exp(v[i].src, v[i].dst, v[i].cnt, v[i].cnt);
      go(v[i].src, v[i].dst, v[i].cnt, v[i].rs, c, e1);
      check("latency", c, v[i].lat);
      check("error", error, 0);
      check("rq_drained", rq.size(), 0);
      check("wq_drained", wq.size(), 0);
      check("cyc_activity", cyc_n != s0, v[i].cnt != 0);
      check("busy_activity", busy_n != b0, v[i].cnt != 0);
    end
    // Timeout: read at 0x200 never acknowledged
    wait_n = 0;
    hang_en = 1'b1;
    hang_addr = 30'h200;
    hold_en = 1'b0;
    s0 = stb_n;
    go(30'h200, 30'hA00, 3, 1'b0, c, e1);
    check("to_latency", c, 9);
    check("to_stb_cycles", stb_n - s0, 8);
    check("to_error", error, 1);
    check("to_cyc", cyc, 0);
    check("to_stb", stb, 0);
    hang_en = 1'b0;
    hold_en = 1'b1;
    push_exp(30'h300, 30'hB00, 1, 1);
    go(30'h300, 30'hB00, 1, 1'b0, c, e1);
    check("err_cleared_on_start", e1, 0);
    check("after_to_error", error, 0);
    check("after_to_latency", c, 6);
    // Slave error (with ack also high) on the write of word 2 of 5
    err_at = wr_n + 2;
    push_exp(30'h500, 30'hC00, 3, 2);
    go(30'h500, 30'hC00, 5, 1'b0, c, e1);
    check("serr_latency", c, 18);
    check("serr_error", error, 1);
    check("serr_rq", rq.size(), 0);
    check("serr_wq", wq.size(), 0);
    err_at = -1;
    // Reset asserted during the first write of a copy
    wait_n = 3;
    push_exp(30'h3FFFFFFF, 30'h20, 1, 0);
    @(negedge clk);
    src_addr = 30'h3FFFFFFF;
    dst_addr = 30'h20;
    word_count = LB'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(cyc && stb && we) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wr_phase_seen", cyc && stb && we, 1);
    hold_en = 1'b0;
    d0 = done_n;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cyc", cyc, 0);
    check("rst_mid_stb", stb, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_done", done_n, d0);
    check("rst_rq", rq.size(), 0);
    check("rst_idle_cyc", cyc, 0);
    hold_en = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_chk, n_pass);
    $fatal(1);
  end
endmodule

// File: doc/wb_boot_copier.md
Name: wb_boot_copier

Overview:
- Wishbone bus master (initiator) that copies a block of 32-bit words from a source region, typically the flash slave, to a destination region such as SRAM.
- Used at boot to move the program image out of flash.
- Issues single classic read cycles, each followed by a single classic write cycle.
- Sits beside the CPU on the system Wishbone interconnect and owns the bus while busy.

Parameters:
- LEN_BITS, 16, width of word_count. Maximum copy is 2^LEN_BITS-1 words.
- TIMEOUT_CYCLES, 255, maximum cycles stb may stay high waiting for ack before the access is aborted. Range 1..255; the counter is 8 bits.

Ports:
- clk  input  1  system clock, also the Wishbone clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse that begins a copy; ignored while busy=1
- src_addr  input  [31:2]  source word address, latched on start
- dst_addr  input  [31:2]  destination word address, latched on start
- word_count  input  LEN_BITS  number of words to copy, latched on start
- busy  output  1  high from the cycle after an accepted start until completion
- done  output  1  one-cycle pulse on completion or abort
- error  output  1  abort flag; set with done, cleared by the next accepted start
- wbm_cyc_o  output  1  bus cycle in progress
- wbm_stb_o  output  1  data strobe
- wbm_addr_o  output  [31:2]  word address
- wbm_cti_o  output  [2:0]  constant 3'b000 (classic)
- wbm_bte_o  output  [1:0]  constant 2'b00 (linear)
- wbm_sel_o  output  [3:0]  constant 4'b1111
- wbm_we_o  output  1  1 for write phase
- wbm_data_o  output  [31:0]  write data
- wbm_data_i  input  [31:0]  read data
- wbm_ack_i  input  1  slave acknowledge
- wbm_err_i  input  1  slave error

Behaviour:
- All outputs are registered.
- Reset values: cyc, stb, we, busy, done and error are 0; addr and data_o are 0; the index counter is 0; state is IDLE.
- rst asserted mid-copy: cyc and stb fall at that edge and there is no done pulse.

States and transitions:
- IDLE: on start with word_count != 0, latch inputs, set i=0, clear error, set busy, go to RD.
- IDLE, zero length: on start with word_count == 0, pulse done in the next cycle with no bus activity; busy stays 0.
- RD: cyc=stb=1, we=0, addr=src+i. On ack, capture wbm_data_i into buf and go to GAP_W.
- GAP_W: cyc=stb=0 for exactly one cycle, then go to WR.
- WR: cyc=stb=1, we=1, addr=dst+i, data_o=buf. On ack, increment i.
  - If i+1 == count: go to IDLE with busy=0 and a done pulse in the same cycle.
  - Otherwise go to GAP_R.
- GAP_R: one idle cycle, then go to RD.

Timing:
- With the start edge at cycle k, stb is first high in cycle k+1.
- Each bus access ends on the edge where ack=1 is sampled; stb is low in the next cycle.
- Against a zero-wait slave with ack one cycle after stb, one word takes 6 cycles.

Aborts:
- Timeout: an 8-bit wait counter clears at each stb rise and increments while stb=1 and ack=0. When it reaches TIMEOUT_CYCLES without ack, cyc and stb fall, error=1, done pulses, busy=0, and state returns to IDLE.
- Slave error: wbm_err_i=1 during stb is treated identically to a timeout; read data is not used.
- ack and err high together: err wins.
- ack or err while stb=0: ignored.

Other rules:
- start while busy is ignored; latched values do not change.
- Address arithmetic is modulo 2^30, so src+i and dst+i wrap past 0x3FFFFFFF to 0.

Decomposition:
- Package wb_pkg holds:
  - WB_CTI_CLASSIC = 3'b000
  - WB_BTE_LINEAR = 2'b00
  - WB_SEL_WORD = 4'b1111
  - the copier state encoding (IDLE, RD, GAP_W, WR, GAP_R)
- One sub-module, wb_master_access: single-access engine that owns cyc, stb, we, addr, data_o and the timeout counter.
  - Inputs: req, we, addr, wdata.
  - Returns a one-cycle ok/fail pulse and rdata.
- wb_boot_copier holds the sequencing FSM, the index counter and buf.

Test Plan:
- Basic copy: zero-wait slave model, src=0x100, dst=0x800, count=4, source words 0xA0..0xA3. Expect writes to 0x800..0x803 with matching data, done pulse 24 cycles after start, error=0.
- Zero length: count=0. Expect done high in cycle k+1, cyc never asserted, busy stays 0.
- Wait states and busy start: slave inserts 3 wait cycles per access; start pulsed again mid-copy. Expect correct copy, second start ignored, stb held steady until ack.
- Timeout: slave never acks at src=0x200 with TIMEOUT_CYCLES=8. Expect stb high 8 cycles, then cyc=stb=0, error=1, done pulse. A following start clears error.
- Slave error on write: wbm_err_i asserted on the write of word 2 of 5. Expect abort after that cycle, only words 0–1 written, error=1.
- Wrap and reset: src=0x3FFFFFFF, count=2. Expect second read at address 0. Then rst asserted mid-WR: cyc and stb fall at that edge, busy=0, no done.
